// File: rtl/bp_be_cmd_pkg.sv
// Shared widths, queue depth and issuer state encoding for the backend
// command path.
package bp_be_cmd_pkg;

    localparam int bp_be_cmd_width_gp     = 114;
    localparam int bp_be_cmd_queue_els_gp = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } bp_be_cmd_issuer_state_e;

endpackage

// File: rtl/bp_be_cmd_credit_counter.sv
// Up/down credit counter that resets to max_p, saturates at both ends and
// raises a sticky flag when a credit comes back while already full.
module bp_be_cmd_credit_counter #(
    parameter int  max_p    = 4,
    localparam int width_lp = $clog2(max_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o,
    output logic                overflow_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_p);

    logic [width_lp-1:0] count_r, count_n;
    logic                err_r, err_n;

    // Simultaneous up and down cancel; a return on a full counter is an error.
    always_comb begin
        count_n = count_r;
        err_n   = err_r;
        case ({up_i, down_i})
            2'b10: begin
                if (count_r == max_lp) err_n = 1'b1;
                else                   count_n = count_r + 1'b1;
            end
            2'b01: begin
                if (count_r != '0) count_n = count_r - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= max_lp;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_n;
            err_r   <= err_n;
        end
    end

    assign count_o    = count_r;
    assign overflow_o = err_r;

endmodule

// File: rtl/bp_be_cmd_issuer.sv
// Producer side of the backend command queue: one-entry issue register that
// writes the queue only when a free slot is guaranteed by the credit count.
module bp_be_cmd_issuer
    import bp_be_cmd_pkg::*;
#(
    parameter int  els_p           = bp_be_cmd_queue_els_gp,
    parameter int  cmd_width_p     = bp_be_cmd_width_gp,
    localparam int credit_width_lp = $clog2(els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [cmd_width_p-1:0]     cmd_i,
    input  logic                       cmd_fence_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    input  logic                       flush_i,
    output logic [cmd_width_p-1:0]     fe_cmd_o,
    output logic                       fe_cmd_v_o,
    input  logic                       fe_cmd_yumi_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       credit_err_o,
    output bp_be_cmd_issuer_state_e    state_o
);

    // Handshake: upstream transfers on cmd_v_i & cmd_ready_o; ready never
    // depends on cmd_v_i. The queue write (fe_cmd_v_o) has no ready: it is only
    // raised when credits guarantee a slot. fe_cmd_yumi_i is the consumer's
    // dequeue and simply returns one credit.

    localparam logic [credit_width_lp-1:0] full_lp = credit_width_lp'(els_p);

    bp_be_cmd_issuer_state_e state_r, state_n;
    logic                    hold_v;
    logic                    hold_fence;
    logic [cmd_width_p-1:0]  hold_data;
    logic                    can_issue;
    logic                    accept;
    logic [credit_width_lp-1:0] credits;

    assign hold_v = (state_r == HELD);

    // A fence waits for a fully drained queue; anything else needs one slot.
    assign can_issue   = hold_v & (hold_fence ? (credits == full_lp) : (credits != '0));
    assign fe_cmd_v_o  = can_issue & ~flush_i;
    assign cmd_ready_o = ~reset_i & ~flush_i & (~hold_v | fe_cmd_v_o);
    assign accept      = cmd_v_i & cmd_ready_o;
    assign fe_cmd_o    = hold_data;
    assign state_o     = state_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= EMPTY;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            EMPTY: if (accept) state_n = HELD;
            HELD: begin
                if (flush_i)                  state_n = EMPTY;
                else if (fe_cmd_v_o & ~accept) state_n = EMPTY;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_fence <= 1'b0;
            hold_data  <= '0;
        end else if (accept) begin
            hold_fence <= cmd_fence_i;
            hold_data  <= cmd_i;
        end
    end

    bp_be_cmd_credit_counter #(
        .max_p(els_p)
    ) credit_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .up_i      (fe_cmd_yumi_i),
        .down_i    (fe_cmd_v_o),
        .count_o   (credits),
        .overflow_o(credit_err_o)
    );

    assign credits_o = credits;

endmodule

// File: tb/tb_bp_be_cmd_issuer.sv
// Randomized and directed bench for bp_be_cmd_issuer with a queue-level
// reference model and an issue scoreboard.
module tb_bp_be_cmd_issuer;
    import bp_be_cmd_pkg::*;

    localparam int W   = bp_be_cmd_width_gp;
    localparam int ELS = bp_be_cmd_queue_els_gp;
    localparam int CW  = $clog2(ELS + 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [W-1:0]  cmd_i;
    logic          cmd_fence_i;
    logic          cmd_v_i;
    logic          cmd_ready_o;
    logic          flush_i;
    logic [W-1:0]  fe_cmd_o;
    logic          fe_cmd_v_o;
    logic          fe_cmd_yumi_i;
    logic [CW-1:0] credits_o;
    logic          credit_err_o;
    bp_be_cmd_issuer_state_e state_o;

    bp_be_cmd_issuer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cmd_i        (cmd_i),
        .cmd_fence_i  (cmd_fence_i),
        .cmd_v_i      (cmd_v_i),
        .cmd_ready_o  (cmd_ready_o),
        .flush_i      (flush_i),
        .fe_cmd_o     (fe_cmd_o),
        .fe_cmd_v_o   (fe_cmd_v_o),
        .fe_cmd_yumi_i(fe_cmd_yumi_i),
        .credits_o    (credits_o),
        .credit_err_o (credit_err_o),
        .state_o      (state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int assertions = 0;
    int failures   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: held command lives at the back of exp_q
    logic [W-1:0] exp_q[$];
    bit  m_hold, m_fence, m_err;
    int  m_credits;
    bit  mon_en = 0;
    bit  exp_v, exp_ready, accept, last_accept;
    bit  obs_v, obs_ready;
    int  issue_cnt;
    logic [W-1:0] popped;

    task automatic model_reset();
        m_hold = 0; m_fence = 0; m_err = 0; m_credits = ELS;
        exp_q.delete();
    endtask

    // monitor: compares every cycle, pops on each queue write, advances model
    always @(negedge clk_i) begin
        if (mon_en) begin
            exp_v     = m_hold && (m_fence ? (m_credits == ELS) : (m_credits != 0)) && !flush_i;
            exp_ready = !flush_i && (!m_hold || exp_v);
            check("fe_cmd_v", 128'(fe_cmd_v_o), 128'(exp_v));
            check("cmd_ready", 128'(cmd_ready_o), 128'(exp_ready));
            check("credits", 128'(credits_o), 128'(m_credits));
            check("credit_err", 128'(credit_err_o), 128'(m_err));
            check("state_held", 128'(state_o == HELD), 128'(m_hold));
            obs_v     = fe_cmd_v_o;
            obs_ready = cmd_ready_o;
            if (fe_cmd_v_o) begin
                issue_cnt++;
                if (exp_q.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("FAIL issue_unexpected: got write of %0h with nothing outstanding", fe_cmd_o);
                end else begin
                    popped = exp_q.pop_front();
                    check("fe_cmd_data", 128'(fe_cmd_o), 128'(popped));
                end
            end
            accept      = cmd_v_i && exp_ready;
            last_accept = accept;
            if (fe_cmd_yumi_i && !exp_v && m_credits == ELS) m_err = 1;
            else m_credits = m_credits + int'(fe_cmd_yumi_i) - int'(exp_v);
            if (accept) begin
                m_hold  = 1;
                m_fence = cmd_fence_i;
                exp_q.push_back(cmd_i);
            end else if (flush_i && m_hold) begin
                m_hold = 0;
                if (exp_q.size() != 0) void'(exp_q.pop_back());
            end else if (exp_v) begin
                m_hold = 0;
            end
        end
    end

    function automatic logic [W-1:0] rand_cmd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // driver: apply one cycle of inputs, return after the monitor has sampled
    task automatic cycle(input logic v, input logic f, input logic fl, input logic y);
        @(posedge clk_i);
        #1;
        cmd_v_i       = v;
        cmd_fence_i   = f;
        cmd_i         = rand_cmd();
        flush_i       = fl;
        fe_cmd_yumi_i = y;
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        int n, guard;
        reset_i = 1; cmd_i = '0; cmd_fence_i = 0; cmd_v_i = 0;
        flush_i = 0; fe_cmd_yumi_i = 0;
        model_reset();

        #12;
        check("rst_ready", 128'(cmd_ready_o), 128'(0));
        check("rst_v", 128'(fe_cmd_v_o), 128'(0));
        check("rst_data", 128'(fe_cmd_o), 128'(0));
        check("rst_credits", 128'(credits_o), 128'(ELS));
        check("rst_err", 128'(credit_err_o), 128'(0));
        @(posedge clk_i);
        #1;
        reset_i = 0;
        mon_en  = 1;

        // six back-to-back commands, no dequeues
        issue_cnt = 0;
        n = 0;
        guard = 0;
        while (n < 5 && guard < 12) begin
            cycle(1, 0, 0, 0);
            if (last_accept) n++;
            guard++;
        end
        check("t1_accepts", 128'(n), 128'(5));
        cycle(1, 0, 0, 0);
        check("t1_ready_stall", 128'(obs_ready), 128'(0));
        check("t1_issues", 128'(issue_cnt), 128'(4));
        check("t1_credits", 128'(credits_o), 128'(0));

        // one dequeue frees the fifth command
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("t2_issue_after_yumi", 128'(obs_v), 128'(1));
        cycle(1, 0, 0, 1);
        check("t2_credits_zero", 128'(credits_o), 128'(0));
        cycle(0, 0, 0, 1);
        check("t2_issue_with_yumi", 128'(obs_v), 128'(1));
        cycle(0, 0, 0, 0);
        check("t2_credits_unchanged", 128'(credits_o), 128'(1));

        // fence with two credits waits for a drained queue
        cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 0);
        check("t3_fence_accepted", 128'(obs_ready), 128'(1));
        cycle(1, 0, 0, 1);
        check("t3_fence_wait_v", 128'(obs_v), 128'(0));
        check("t3_fence_wait_ready", 128'(obs_ready), 128'(0));
        cycle(1, 0, 0, 1);
        check("t3_fence_wait_v3", 128'(obs_v), 128'(0));
        cycle(1, 0, 0, 0);
        check("t3_fence_issue", 128'(obs_v), 128'(1));
        check("t3_follow_accept", 128'(obs_ready), 128'(1));
        cycle(0, 0, 0, 0);

        // flush a command stuck behind zero credits
        guard = 0;
        while (!(m_hold && m_credits == 0) && guard < 10) begin
            cycle(1, 0, 0, 0);
            guard++;
        end
        check("t4_setup", 128'(m_hold && m_credits == 0), 128'(1));
        cycle(0, 0, 1, 0);
        check("t4_flush_ready", 128'(obs_ready), 128'(0));
        check("t4_flush_v", 128'(obs_v), 128'(0));
        cycle(0, 0, 0, 0);
        check("t4_after_ready", 128'(obs_ready), 128'(1));
        check("t4_after_credits", 128'(credits_o), 128'(0));
        check("t4_after_state", 128'(state_o == HELD), 128'(0));

        // credit return on a full counter
        guard = 0;
        while (m_credits < ELS && guard < 10) begin
            cycle(0, 0, 0, 1);
            guard++;
        end
        check("t5_drained", 128'(m_credits), 128'(ELS));
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("t5_err_set", 128'(credit_err_o), 128'(1));
        check("t5_credits_sat", 128'(credits_o), 128'(ELS));
        cycle(0, 0, 0, 0);
        check("t5_err_sticky", 128'(credit_err_o), 128'(1));

        // async reset while a command is issuing with one credit left
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        @(posedge clk_i);
        #1;
        cmd_v_i = 0;
        #2;
        check("t6_pre_v", 128'(fe_cmd_v_o), 128'(1));
        check("t6_pre_credits", 128'(credits_o), 128'(1));
        mon_en  = 0;
        reset_i = 1;
        #1;
        check("t6_async_v", 128'(fe_cmd_v_o), 128'(0));
        check("t6_async_credits", 128'(credits_o), 128'(ELS));
        check("t6_async_ready", 128'(cmd_ready_o), 128'(0));
        check("t6_async_err", 128'(credit_err_o), 128'(0));
        #3;
        reset_i = 0;
        model_reset();
        mon_en = 1;

        // random traffic with legal dequeues
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 15) == 0,
                  (m_credits < ELS) && ($urandom_range(0, 1) == 1));
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
